clk_activity_led: RTL and testbench

//  Parametrised, fully synchronous clock-activity indicator; successor to the 2-stage ripple LED counter.

---
 rtl/clk_activity_led.sv | 124 ++++++++++++
 tb/tb_clk_activity_led.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_activity_led.sv
// Clock-activity indicator: counts enabled clk cycles and drives N_LED LEDs
// as a binary readout, a bouncing scanner, a PWM breathing pattern, or a
// frozen snapshot. Fully synchronous; all outputs registered.
//
// state (scanner)        | meaning
// -----------------------|----------------------------------------------
// scan_up=1, pos<LAST    | moving toward LED N_LED-1, step +1 per tick
// scan_up=1, pos==LAST   | at top end, next tick turns around to LAST-1
// scan_up=0, pos>0       | moving toward LED 0, step -1 per tick
// scan_up=0, pos==0      | at bottom end, next tick turns around to 1
module clk_activity_led #(
    parameter int CNT_W      = 30,
    parameter int N_LED      = 4,
    parameter int PWM_W      = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    localparam int LO_W  = CNT_W - N_LED;
    localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
    localparam logic [N_LED-1:0] LED_OFF  = {N_LED{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_FREEZE  = 2'd3
    } mode_t;

    mode_t            mode_sel;
    logic [POS_W-1:0] scan_pos;
    logic             scan_up;
    logic             lo_full;
    logic [PWM_W-1:0] ramp;
    logic [PWM_W-1:0] duty;
    logic             pwm_lit;
    logic [N_LED-1:0] raw;

    assign mode_sel = mode_t'(mode);

    // Low field is about to wrap when it is all ones; that increment earns a tick.
    assign lo_full = &count[LO_W-1:0];

    // Activity counter: clear beats enable, free wrap at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Tick marks the cycle after an enabled increment that zeroed the low field.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick <= 1'b0;
        end else begin
            tick <= !clear && en && lo_full;
        end
    end

    // Bouncing scanner, stepped by tick and kept alive in every display mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_pos <= '0;
            scan_up  <= 1'b1;
        end else if (clear) begin
            scan_pos <= '0;
            scan_up  <= 1'b1;
        end else if (tick && (N_LED > 1)) begin
            if (scan_up) begin
                if (scan_pos == POS_LAST) begin
                    scan_up  <= 1'b0;
                    scan_pos <= scan_pos - POS_W'(1);
                end else begin
                    scan_pos <= scan_pos + POS_W'(1);
                end
            end else begin
                if (scan_pos == '0) begin
                    scan_up  <= 1'b1;
                    scan_pos <= scan_pos + POS_W'(1);
                end else begin
                    scan_pos <= scan_pos - POS_W'(1);
                end
            end
        end
    end

    // Active-high display pattern for the live modes; breathing folds the ramp
    // on the counter MSB so brightness rises then falls.
    always_comb begin
        ramp    = count[CNT_W-2 -: PWM_W];
        duty    = count[CNT_W-1] ? ~ramp : ramp;
        pwm_lit = (count[PWM_W-1:0] < duty);
        raw     = '0;
        case (mode_sel)
            MODE_BINARY:  raw = count[CNT_W-1 -: N_LED];
            MODE_SCAN:    raw = N_LED'(1) << scan_pos;
            MODE_BREATHE: raw = {N_LED{pwm_lit}};
            default:      raw = '0;
        endcase
    end

    // LED register: polarity applied here; freeze simply holds the last drive.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led <= LED_OFF;
        end else if (mode_sel != MODE_FREEZE) begin
            led <= ACTIVE_LOW ? ~raw : raw;
        end
    end

endmodule

// File: tb/tb_clk_activity_led.sv
// Bench for clk_activity_led at CNT_W=8, N_LED=4, PWM_W=2, with an
// active-low and an active-high instance sharing the same stimulus.
module tb_clk_activity_led;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] count, count_ah;
    logic       tick, tick_ah;
    logic [3:0] led, led_ah;

    clk_activity_led #(.CNT_W(8), .N_LED(4), .PWM_W(2), .ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .mode(mode),
        .count(count), .tick(tick), .led(led)
    );

    clk_activity_led #(.CNT_W(8), .N_LED(4), .PWM_W(2), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .mode(mode),
        .count(count_ah), .tick(tick_ah), .led(led_ah)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] count;
        logic       tick;
        logic [3:0] led;
        logic [3:0] led_ah;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference state: scanner kept as an index into its bounce sequence.
    logic [7:0] m_count = 8'h00;
    logic       m_tick = 1'b0;
    int         m_idx = 0;
    logic [3:0] m_lit = 4'h0;
    int         seq_pos[6] = '{0, 1, 2, 3, 2, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [1:0] md);
        exp_t       x;
        logic [3:0] raw;
        logic [1:0] ramp, duty;
        reset_n = r;
        en      = e;
        clear   = c;
        mode    = md;
        ramp = m_count[6:5];
        duty = m_count[7] ? ~ramp : ramp;
        case (md)
            2'd0:    raw = m_count[7:4];
            2'd1:    raw = 4'b0001 << seq_pos[m_idx];
            2'd2:    raw = (m_count[1:0] < duty) ? 4'hF : 4'h0;
            default: raw = m_lit;
        endcase
        if (!r) begin
            m_count = 8'h00;
            m_tick  = 1'b0;
            m_idx   = 0;
            m_lit   = 4'h0;
        end else begin
            m_lit = raw;
            if (c) m_idx = 0;
            else if (m_tick) m_idx = (m_idx + 1) % 6;
            m_tick = !c && e && (m_count[3:0] == 4'hF);
            if (c) m_count = 8'h00;
            else if (e) m_count = m_count + 8'h01;
        end
        x.count  = m_count;
        x.tick   = m_tick;
        x.led    = ~m_lit;
        x.led_ah = m_lit;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("sb_count", count, x.count);
        chk("sb_tick", tick, x.tick);
        chk("sb_led", led, x.led);
        chk("sb_led_ah", led_ah, x.led_ah);
        chk("sb_count_ah", count_ah, x.count);
        chk("sb_tick_ah", tick_ah, x.tick);
    endtask

    initial begin
        int         ticks;
        int         nlit;
        int         guard;
        logic [7:0] c0;
        logic [7:0] diff;
        logic [3:0] seen[$];
        logic [3:0] scan_exp[7] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hB, 4'hD, 4'hE};

        // Reset and polarity
        repeat (3) step(1'b0, 1'b1, 1'b0, 2'd1);
        chk("rst_count", count, 8'h00);
        chk("rst_tick", tick, 1'b0);
        chk("rst_led", led, 4'hF);
        chk("rst_led_ah", led_ah, 4'h0);

        // Binary mode through a full wrap
        ticks = 0;
        repeat (256) begin
            step(1'b1, 1'b1, 1'b0, 2'd0);
            if (tick) ticks++;
        end
        chk("wrap_count", count, 8'h00);
        chk("wrap_ticks", ticks, 16);
        repeat (48) step(1'b1, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 2'd0);
        chk("bin_30_led", led, 4'b1100);

        // Scanner bounce
        step(1'b1, 1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b0, 1'b0, 2'd1);
        seen.push_back(led);
        repeat (100) begin
            step(1'b1, 1'b1, 1'b0, 2'd1);
            if (led != seen[$]) seen.push_back(led);
        end
        chk("scan_steps", seen.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < seen.size()) chk("scan_seq", seen[i], scan_exp[i]);
        end

        // Clear against enable at the tick boundary
        step(1'b1, 1'b0, 1'b1, 2'd0);
        repeat (127) step(1'b1, 1'b1, 1'b0, 2'd0);
        chk("pre_clr_count", count, 8'h7F);
        step(1'b1, 1'b1, 1'b1, 2'd1);
        chk("clr_count", count, 8'h00);
        chk("clr_tick", tick, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'd1);
        chk("clr_en_count", count, 8'h01);
        chk("clr_pos_led", led, 4'hE);

        // Freeze with the scanner parked on LED 2
        guard = 0;
        while (led != 4'b1011 && guard < 200) begin
            step(1'b1, 1'b1, 1'b0, 2'd1);
            guard++;
        end
        chk("frz_reach", led, 4'b1011);
        c0 = count;
        nlit = 0;
        repeat (64) begin
            step(1'b1, 1'b1, 1'b0, 2'd3);
            if (led != 4'b1011) nlit++;
        end
        diff = count - c0;
        chk("frz_changes", nlit, 0);
        chk("frz_advance", diff, 8'd64);
        step(1'b1, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b0, 2'd1);

        // Breathing, then reset in the middle of a run
        step(1'b1, 1'b0, 1'b1, 2'd2);
        step(1'b1, 1'b0, 1'b0, 2'd2);
        chk("brth_off", led, 4'hF);
        repeat (96) step(1'b1, 1'b1, 1'b0, 2'd2);
        chk("brth_at_60", count, 8'h60);
        nlit = 0;
        repeat (16) begin
            step(1'b1, 1'b1, 1'b0, 2'd2);
            if (led == 4'h0) nlit++;
        end
        chk("brth_lit", nlit, 12);
        step(1'b0, 1'b1, 1'b0, 2'd2);
        chk("mid_rst_count", count, 8'h00);
        chk("mid_rst_tick", tick, 1'b0);
        chk("mid_rst_led", led, 4'hF);
        repeat (4) step(1'b1, 1'b1, 1'b0, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d of %0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
